// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO, standard or FWFT read, live thresholds.
// Define SYNC_FIFO_PROG_PEAK_LEVEL_EN to add the peak_level output.
module sync_fifo_prog #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  parameter  int FWFT  = 0,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wren,
  input  logic [WIDTH-1:0] din,
  input  logic             rden,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level,
  input  logic [LW-1:0]    af_thresh,
  input  logic [LW-1:0]    ae_thresh,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
`ifdef SYNC_FIFO_PROG_PEAK_LEVEL_EN
  ,
  output logic [LW-1:0]    peak_level
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full_w;
  logic             empty_w;
  logic [LW-1:0]    mem_cnt;
  logic             wr_acc;
  logic             rd_acc;
  logic             ovf_evt;
  logic             unf_evt;
  logic             load;

  assign full_w = (level_q == DEPTH_L);

  // In FWFT mode the output register holds one of the counted words.
  assign mem_cnt = (FWFT != 0)
                 ? level_q - LW'(dout_valid_q)
                 : level_q;

  assign empty_w = (FWFT != 0)
                 ? !dout_valid_q
                 : (level_q == '0);

  // Accept/reject decisions from pre-edge state; flush masks everything.
  always_comb begin
    wr_acc  = wren && !full_w  && !flush;
    rd_acc  = rden && !empty_w && !flush;
    ovf_evt = wren && full_w   && !flush;
    unf_evt = rden && empty_w  && !flush;
  end

  // Pointer, level and output-register next state.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    load         = 1'b0;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      dout_valid_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + ONE_P;
      end
      unique case (1'b1)
        wr_acc && !rd_acc: level_d = level_q + ONE_L;
        rd_acc && !wr_acc: level_d = level_q - ONE_L;
        default:           level_d = level_q;
      endcase
      if (FWFT != 0) begin
        dout_valid_d = dout_valid_q && !rd_acc;
        load = (!dout_valid_q || rd_acc)
             && (mem_cnt != '0);
        if (load) begin
          dout_d       = mem_q[rd_ptr_q];
          dout_valid_d = 1'b1;
          rd_ptr_d     = rd_ptr_q + ONE_P;
        end
      end else begin
        if (rd_acc) begin
          dout_d       = mem_q[rd_ptr_q];
          dout_valid_d = 1'b1;
          rd_ptr_d     = rd_ptr_q + ONE_P;
        end
      end
    end
  end

  // Sticky error flags; an event in the clear cycle keeps the flag set.
  always_comb begin
    overflow_d  = (overflow_q  && !clr_err) || ovf_evt;
    underflow_d = (underflow_q && !clr_err) || unf_evt;
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign level        = level_q;
  assign almost_full  = (level_q >= af_thresh);
  assign almost_empty = (level_q <= ae_thresh);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

`ifdef SYNC_FIFO_PROG_PEAK_LEVEL_EN
  logic [LW-1:0] peak_q, peak_d;

  // High-water mark, restarted by flush or clr_err.
  always_comb begin
    peak_d = peak_q;
    if (flush || clr_err) begin
      peak_d = '0;
    end else if (level_q > peak_q) begin
      peak_d = level_q;
    end
  end

  // High-water mark register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: standard and FWFT instances on shared stimulus,
// each checked every cycle against a queue-based model.
module tb_sync_fifo_prog;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          wren = 1'b0;
  logic          rden = 1'b0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  din = '0;
  logic [LW-1:0] af_thresh = '0;
  logic [LW-1:0] ae_thresh = 5'd3;

  logic [W-1:0]  s_dout, f_dout;
  logic          s_dv, f_dv, s_full, f_full, s_empty, f_empty;
  logic [LW-1:0] s_level, f_level;
  logic          s_af, f_af, s_ae, f_ae;
  logic          s_ovf, f_ovf, s_unf, f_unf;
  logic [LW-1:0] s_pk, f_pk;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wren(wren), .din(din), .rden(rden),
    .dout(s_dout), .dout_valid(s_dv),
    .full(s_full), .empty(s_empty), .level(s_level),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(s_af), .almost_empty(s_ae),
    .overflow(s_ovf), .underflow(s_unf),
    .clr_err(clr_err)
`ifdef SYNC_FIFO_PROG_PEAK_LEVEL_EN
    , .peak_level(s_pk)
`endif
  );

  sync_fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fw (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wren(wren), .din(din), .rden(rden),
    .dout(f_dout), .dout_valid(f_dv),
    .full(f_full), .empty(f_empty), .level(f_level),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(f_af), .almost_empty(f_ae),
    .overflow(f_ovf), .underflow(f_unf),
    .clr_err(clr_err)
`ifdef SYNC_FIFO_PROG_PEAK_LEVEL_EN
    , .peak_level(f_pk)
`endif
  );

`ifndef SYNC_FIFO_PROG_PEAK_LEVEL_EN
  assign s_pk = '0;
  assign f_pk = '0;
`endif

  task automatic chk1(input string nm, input logic a, input logic e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0b, expected %0b (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic chkl(input string nm, input logic [LW-1:0] a,
                      input logic [LW-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [W-1:0] a,
                      input logic [W-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  // Reference model: a word queue per instance. In FWFT mode the head
  // is shown once it was written at an earlier edge than the current one.
  typedef struct {
    logic [W-1:0] d;
    int           e;
  } ent_t;

  ent_t         q_s[$];
  ent_t         q_f[$];
  int           edge_n = 0;
  logic [W-1:0] m_dout_s = '0;
  logic [W-1:0] m_dout_f = '0;
  bit           m_dv_s = 1'b0;
  bit           m_v_f = 1'b0;
  bit           m_ovf_s = 1'b0, m_ovf_f = 1'b0;
  bit           m_unf_s = 1'b0, m_unf_f = 1'b0;
  int           m_pk_s = 0, m_pk_f = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_s.delete();
      q_f.delete();
      edge_n   = 0;
      m_dout_s = '0;
      m_dout_f = '0;
      m_dv_s   = 1'b0;
      m_v_f    = 1'b0;
      m_ovf_s  = 1'b0;
      m_ovf_f  = 1'b0;
      m_unf_s  = 1'b0;
      m_unf_f  = 1'b0;
      m_pk_s   = 0;
      m_pk_f   = 0;
    end else begin
      int  ns, nf;
      bit  fs, ff, es, ef;
      ent_t hd;
      edge_n++;
      ns = q_s.size();
      nf = q_f.size();
      fs = (ns == D);
      ff = (nf == D);
      es = (ns == 0);
      ef = !m_v_f;
      m_ovf_s = (m_ovf_s && !clr_err) || (!flush && wren && fs);
      m_ovf_f = (m_ovf_f && !clr_err) || (!flush && wren && ff);
      m_unf_s = (m_unf_s && !clr_err) || (!flush && rden && es);
      m_unf_f = (m_unf_f && !clr_err) || (!flush && rden && ef);
      m_pk_s = (flush || clr_err) ? 0 : (ns > m_pk_s ? ns : m_pk_s);
      m_pk_f = (flush || clr_err) ? 0 : (nf > m_pk_f ? nf : m_pk_f);
      m_dv_s = 1'b0;
      if (flush) begin
        q_s.delete();
        q_f.delete();
        m_v_f = 1'b0;
      end else begin
        if (rden && !es) begin
          hd = q_s.pop_front();
          m_dout_s = hd.d;
          m_dv_s = 1'b1;
        end
        if (wren && !fs) q_s.push_back('{din, edge_n});
        if (rden && !ef) hd = q_f.pop_front();
        if (wren && !ff) q_f.push_back('{din, edge_n});
        m_v_f = (q_f.size() > 0) && (q_f[0].e < edge_n);
        if (m_v_f) m_dout_f = q_f[0].d;
      end
    end
  end

  // Every-cycle comparison, away from the clock edge.
  always @(negedge clk) begin
    #1;
    chkl("s_level", s_level, LW'(q_s.size()));
    chk1("s_full", s_full, q_s.size() == D);
    chk1("s_empty", s_empty, q_s.size() == 0);
    chk1("s_dv", s_dv, m_dv_s);
    chkw("s_dout", s_dout, m_dout_s);
    chk1("s_af", s_af, q_s.size() >= int'(af_thresh));
    chk1("s_ae", s_ae, q_s.size() <= int'(ae_thresh));
    chk1("s_ovf", s_ovf, m_ovf_s);
    chk1("s_unf", s_unf, m_unf_s);
    chkl("f_level", f_level, LW'(q_f.size()));
    chk1("f_full", f_full, q_f.size() == D);
    chk1("f_empty", f_empty, !m_v_f);
    chk1("f_dv", f_dv, m_v_f);
    chkw("f_dout", f_dout, m_dout_f);
    chk1("f_af", f_af, q_f.size() >= int'(af_thresh));
    chk1("f_ae", f_ae, q_f.size() <= int'(ae_thresh));
    chk1("f_ovf", f_ovf, m_ovf_f);
    chk1("f_unf", f_unf, m_unf_f);
`ifdef SYNC_FIFO_PROG_PEAK_LEVEL_EN
    chkl("s_peak", s_pk, LW'(m_pk_s));
    chkl("f_peak", f_pk, LW'(m_pk_f));
`endif
  end

  // Drive one cycle of inputs at the falling edge; return after the
  // next rising edge with outputs settled.
  task automatic step(input logic w, input logic r, input logic [W-1:0] d,
                      input logic f, input logic ce);
    @(negedge clk);
    wren = w;
    rden = r;
    din = d;
    flush = f;
    clr_err = ce;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chkl("rst_level", s_level, 5'd0);
    chk1("rst_empty", s_empty, 1'b1);
    chk1("rst_full", s_full, 1'b0);
    chkw("rst_dout", s_dout, 32'h0);
    chk1("rst_dv", s_dv, 1'b0);
    chk1("rst_ae", s_ae, 1'b1);
    chk1("rst_af_zero_thr", s_af, 1'b1);
    chk1("rst_f_empty", f_empty, 1'b1);
    af_thresh = 5'd12;
    #1;
    chk1("rst_af_thr12", s_af, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < D; i++) begin
      step(1'b1, 1'b0, W'(32'h100 + i), 1'b0, 1'b0);
      if (i == 2) chk1("ae_at_3", s_ae, 1'b1);
      if (i == 3) chk1("ae_at_4", s_ae, 1'b0);
      if (i == 10) begin
        chk1("af_at_11", s_af, 1'b0);
        af_thresh = 5'd10;
        #1;
        chk1("af_thr10_live", s_af, 1'b1);
        af_thresh = 5'd12;
        #1;
      end
      if (i == 11) chk1("af_at_12", s_af, 1'b1);
    end
    chk1("fill_full", s_full, 1'b1);
    chkl("fill_level", s_level, 5'd16);
    chkl("fill_f_level", f_level, 5'd16);
    step(1'b1, 1'b0, 32'hDEAD, 1'b0, 1'b0);
    chk1("ovf_set", s_ovf, 1'b1);
    chk1("ovf_f_set", f_ovf, 1'b1);
    chkl("ovf_level", s_level, 5'd16);

    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b1, '0, 1'b0, 1'b0);
      chk1("rd_dv", s_dv, 1'b1);
      chkw("rd_data", s_dout, W'(32'h100 + i));
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk1("rd_dv_end", s_dv, 1'b0);
    chk1("rd_empty", s_empty, 1'b1);
    chk1("rd_f_empty", f_empty, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk1("clr_ovf", s_ovf, 1'b0);

    step(1'b1, 1'b0, 32'hA5, 1'b0, 1'b0);
    chkl("fw1_level", f_level, 5'd1);
    chk1("fw1_empty", f_empty, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk1("fw1_dv", f_dv, 1'b1);
    chkw("fw1_dout", f_dout, 32'hA5);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    chk1("fw1_pop_empty", f_empty, 1'b1);
    chkw("std_a5", s_dout, 32'hA5);

    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, W'(32'h200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk1("b2b_dv", f_dv, 1'b1);
      chkw("b2b_dout", f_dout, W'(32'h200 + i));
      step(1'b0, 1'b1, '0, 1'b0, 1'b0);
      chkw("b2b_std", s_dout, W'(32'h200 + i));
    end
    chk1("b2b_empty", f_empty, 1'b1);

    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, W'(32'h300 + i), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, W'(32'h400 + i), 1'b0, 1'b0);
      chkl("rw_level", s_level, 5'd5);
      chkl("rw_f_level", f_level, 5'd5);
    end
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
    chkl("erw_level", s_level, 5'd1);
    chk1("erw_unf", s_unf, 1'b1);
    chkl("erw_f_level", f_level, 5'd1);
    chk1("erw_f_unf", f_unf, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, W'(32'h500 + i), 1'b0, 1'b0);
    chkl("pre_flush", s_level, 5'd9);
    step(1'b1, 1'b1, 32'h999, 1'b1, 1'b0);
    chkl("flush_level", s_level, 5'd0);
    chk1("flush_empty", s_empty, 1'b1);
    chk1("flush_ovf", s_ovf, 1'b0);
    chk1("flush_unf", s_unf, 1'b0);
    chk1("flush_f_dv", f_dv, 1'b0);
    step(1'b1, 1'b0, 32'h5A5A, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chkw("aflush_f", f_dout, 32'h5A5A);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    chkw("aflush_s", s_dout, 32'h5A5A);

    for (int i = 0; i < D; i++)
      step(1'b1, 1'b0, $urandom, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hBAD, 1'b0, 1'b1);
    chk1("clr_vs_ovf", s_ovf, 1'b1);
    chk1("clr_vs_ovf_f", f_ovf, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    for (int k = 0; k < 2500; k++) begin
      int pw;
      pw = (((k / 250) % 2) == 0) ? 70 : 30;
      if ($urandom_range(99) < 5) begin
        af_thresh = LW'($urandom_range(16));
        ae_thresh = LW'($urandom_range(16));
      end
      step($urandom_range(99) < pw, $urandom_range(99) < (100 - pw),
           $urandom, $urandom_range(199) == 0, $urandom_range(49) == 0);
    end

    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++)
      step(1'b1, 1'b0, W'(32'h600 + i), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h700, 1'b0, 1'b0);
    chkl("mid_level", s_level, 5'd7);
`ifdef SYNC_FIFO_PROG_PEAK_LEVEL_EN
    chkl("peak_7", s_pk, 5'd7);
    chkl("peak_7_f", f_pk, 5'd7);
`endif
    #1 rst_n = 1'b0;
    #1;
    chkl("arst_level", s_level, 5'd0);
    chk1("arst_empty", s_empty, 1'b1);
    chk1("arst_full", s_full, 1'b0);
    chkw("arst_dout", s_dout, 32'h0);
    chk1("arst_dv", s_dv, 1'b0);
    chk1("arst_ovf", s_ovf, 1'b0);
    chk1("arst_unf", s_unf, 1'b0);
    chk1("arst_ae", s_ae, 1'b1);
    chk1("arst_af", s_af, 1'b0);
    chkl("arst_f_level", f_level, 5'd0);
    chk1("arst_f_dv", f_dv, 1'b0);
    chkw("arst_f_dout", f_dout, 32'h0);
`ifdef SYNC_FIFO_PROG_PEAK_LEVEL_EN
    chkl("arst_peak", s_pk, 5'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wren = 1'b0;
    rden = 1'b0;
    step(1'b1, 1'b0, 32'h1234, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
